fetch_queue: RTL and testbench

Parametrised successor to the single-register fetch stage. It holds the PC, issues sequential requests to a synchronous instruction memory with one-cycle latency, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. The FIFO drains to decode through a valid/ready handshake. A branch redirect flushes the queue and any in-flight request, so decode can stall without stalling the PC register directly.

---
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch stage: PC register, sequential imem requests, DEPTH-entry {instr, pc} queue to decode.
// Latency: 2 cycles from issue to valid_D; a redirect target reaches the head 3 cycles after the redirect.
// Backpressure: ready_D low stops issue once queued + in-flight reaches DEPTH; a pop frees a slot the same cycle.
module fetch_queue #(
    parameter int             N        = 64,
    parameter int             INSTR_W  = 32,
    parameter int             DEPTH    = 4,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int             PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       PCSrc_F,
    input  logic [N-1:0]               PCBranch_F,
    output logic [N-1:0]               imem_addr_F,
    output logic                       imem_req_F,
    input  logic [INSTR_W-1:0]         imem_rdata_F,
    output logic [INSTR_W-1:0]         instr_D,
    output logic [N-1:0]               pc_D,
    output logic                       valid_D,
    input  logic                       ready_D,
    output logic [$clog2(DEPTH+1)-1:0] fq_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [N-1:0]       pc;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [N-1:0]    pc_q;
    logic [N-1:0]    inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occ;
    logic [CW:0]     lim;

    assign valid_D  = (count != '0) && !PCSrc_F;
    assign pop      = valid_D && ready_D;
    assign push     = inflight && !PCSrc_F;

    // The pop credit lets a full queue keep issuing while decode drains it.
    assign occ      = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign lim      = (CW + 1)'(DEPTH) + {{CW{1'b0}}, pop};
    assign issue    = !reset && !PCSrc_F && (occ < lim);

    assign imem_req_F  = issue;
    assign imem_addr_F = pc_q;
    assign instr_D     = mem[rd_ptr].instr;
    assign pc_D        = mem[rd_ptr].pc;
    assign fq_count    = count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (PCSrc_F) begin
            // Redirect drops queued entries and whatever returns this cycle.
            pc_q     <= PCBranch_F;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= pc_q;
                pc_q        <= pc_q + N'(PC_STEP);
            end else begin
                inflight <= 1'b0;
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= '{instr: imem_rdata_F, pc: inflight_pc};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirects, PC wrap and mid-stream reset.
// Inputs change on the falling edge; outputs are sampled 1 ns later within the same cycle.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrc_F = 1'b0;
    logic [63:0] PCBranch_F = '0;
    logic        ready_D = 1'b0;

    logic [63:0] imem_addr_F, pc_D;
    logic        imem_req_F, valid_D;
    logic [31:0] imem_rdata_F, instr_D;
    logic [2:0]  fq_count;

    logic [63:0] addr_w, pc_w;
    logic        req_w, valid_w;
    logic [31:0] rdata_w, instr_w;
    logic [2:0]  count_w;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    fetch_queue #(.N(64), .INSTR_W(32), .DEPTH(4), .RESET_PC(64'h0), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F),
        .imem_addr_F(imem_addr_F), .imem_req_F(imem_req_F), .imem_rdata_F(imem_rdata_F),
        .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D), .ready_D(ready_D),
        .fq_count(fq_count)
    );

    fetch_queue #(.N(64), .INSTR_W(32), .DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .PC_STEP(4)) u_wrap (
        .clk(clk), .reset(reset), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F),
        .imem_addr_F(addr_w), .imem_req_F(req_w), .imem_rdata_F(rdata_w),
        .instr_D(instr_w), .pc_D(pc_w), .valid_D(valid_w), .ready_D(ready_D),
        .fq_count(count_w)
    );

    // Instruction memory contents are a fixed function of the address, so expected instr follows from pc.
    function automatic logic [31:0] mem_f(input logic [63:0] a);
        return {a[63:56], a[23:0]} ^ 32'hC0DE_0001;
    endfunction

    always @(posedge clk) begin
        imem_rdata_F <= mem_f(imem_addr_F);
        rdata_w      <= mem_f(addr_w);
    end

    task automatic cyc(input logic rst, input logic rdy, input logic src, input logic [63:0] br);
        @(negedge clk);
        reset = rst; ready_D = rdy; PCSrc_F = src; PCBranch_F = br;
        #1;
    endtask

    task automatic test_reset();
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 64'h0);
        vec++; if (valid_D !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", valid_D); end
        vec++; if (imem_req_F !== 1'b0) begin errs++; $display("FAIL reset_req: got %b expected 0", imem_req_F); end
        vec++; if (fq_count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d expected 0", fq_count); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            logic [63:0] ea, ep;
            ea = 64'(4 * i);
            ep = 64'(4 * (i - 2));
            cyc(1'b0, 1'b1, 1'b0, 64'h0);
            vec++; if (imem_addr_F !== ea || imem_req_F !== 1'b1) begin
                errs++; $display("FAIL stream_issue c%0d: got addr %h req %b expected addr %h req 1", i, imem_addr_F, imem_req_F, ea);
            end
            if (i < 2) begin
                vec++; if (valid_D !== 1'b0) begin errs++; $display("FAIL stream_novalid c%0d: got %b expected 0", i, valid_D); end
            end else begin
                vec++; if (valid_D !== 1'b1 || pc_D !== ep || instr_D !== mem_f(ep)) begin
                    errs++; $display("FAIL stream_head c%0d: got v %b pc %h instr %h expected v 1 pc %h instr %h", i, valid_D, pc_D, instr_D, ep, mem_f(ep));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        cyc(1'b1, 1'b1, 1'b0, 64'h0);
        for (int c = 0; c < 15; c++) begin
            logic [63:0] ep;
            cyc(1'b0, (c < 4 || c >= 9), 1'b0, 64'h0);
            if (c == 2 || c == 3) begin
                ep = 64'(4 * (c - 2));
                vec++; if (valid_D !== 1'b1 || pc_D !== ep) begin errs++; $display("FAIL bp_accept c%0d: got v %b pc %h expected v 1 pc %h", c, valid_D, pc_D, ep); end
            end
            if (c >= 4 && c <= 10) begin
                logic [2:0] ec;
                logic       er;
                case (c)
                    4: begin ec = 3'd1; er = 1'b1; end
                    5: begin ec = 3'd2; er = 1'b1; end
                    6: begin ec = 3'd3; er = 1'b0; end
                    7: begin ec = 3'd4; er = 1'b0; end
                    8: begin ec = 3'd4; er = 1'b0; end
                    9: begin ec = 3'd4; er = 1'b1; end
                    default: begin ec = 3'd3; er = 1'b1; end
                endcase
                vec++; if (fq_count !== ec || imem_req_F !== er) begin
                    errs++; $display("FAIL bp_fill c%0d: got count %0d req %b expected count %0d req %b", c, fq_count, imem_req_F, ec, er);
                end
            end
            if (c == 7 || c == 8) begin
                vec++; if (imem_addr_F !== 64'd24) begin errs++; $display("FAIL bp_pc_hold c%0d: got %h expected 18", c, imem_addr_F); end
            end
            if (c >= 9) begin
                ep = 64'(8 + 4 * (c - 9));
                vec++; if (valid_D !== 1'b1 || pc_D !== ep || instr_D !== mem_f(ep)) begin
                    errs++; $display("FAIL bp_drain c%0d: got v %b pc %h expected v 1 pc %h", c, valid_D, pc_D, ep);
                end
            end
        end
    endtask

    task automatic test_redirect();
        cyc(1'b1, 1'b0, 1'b0, 64'h0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 64'h0);
        // cycle 4: three queued entries, pc 12 in flight
        cyc(1'b0, 1'b1, 1'b1, 64'h5);
        vec++; if (valid_D !== 1'b0 || imem_req_F !== 1'b0 || fq_count !== 3'd3) begin
            errs++; $display("FAIL redir_cycle: got v %b req %b count %0d expected v 0 req 0 count 3", valid_D, imem_req_F, fq_count);
        end
        cyc(1'b0, 1'b1, 1'b0, 64'h0);
        vec++; if (fq_count !== 3'd0 || valid_D !== 1'b0 || imem_addr_F !== 64'd5 || imem_req_F !== 1'b1) begin
            errs++; $display("FAIL redir_after: got count %0d v %b addr %h req %b expected count 0 v 0 addr 5 req 1", fq_count, valid_D, imem_addr_F, imem_req_F);
        end
        cyc(1'b0, 1'b1, 1'b0, 64'h0);
        vec++; if (valid_D !== 1'b0 || imem_addr_F !== 64'd9) begin
            errs++; $display("FAIL redir_gap: got v %b addr %h expected v 0 addr 9", valid_D, imem_addr_F);
        end
        cyc(1'b0, 1'b1, 1'b0, 64'h0);
        vec++; if (valid_D !== 1'b1 || pc_D !== 64'd5 || instr_D !== mem_f(64'd5)) begin
            errs++; $display("FAIL redir_head: got v %b pc %h instr %h expected v 1 pc 5", valid_D, pc_D, instr_D);
        end
        cyc(1'b0, 1'b1, 1'b0, 64'h0);
        vec++; if (valid_D !== 1'b1 || pc_D !== 64'd9) begin
            errs++; $display("FAIL redir_next: got v %b pc %h expected v 1 pc 9", valid_D, pc_D);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 1'b1, 1'b0, 64'h0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 64'h0);
        cyc(1'b0, 1'b1, 1'b1, 64'h100);
        vec++; if (imem_req_F !== 1'b0 || valid_D !== 1'b0) begin errs++; $display("FAIL b2b_first: got req %b v %b expected 0 0", imem_req_F, valid_D); end
        cyc(1'b0, 1'b1, 1'b1, 64'h200);
        vec++; if (imem_req_F !== 1'b0 || valid_D !== 1'b0) begin errs++; $display("FAIL b2b_second: got req %b v %b expected 0 0", imem_req_F, valid_D); end
        cyc(1'b0, 1'b1, 1'b0, 64'h0);
        vec++; if (imem_addr_F !== 64'h200 || imem_req_F !== 1'b1) begin
            errs++; $display("FAIL b2b_issue: got addr %h req %b expected addr 200 req 1", imem_addr_F, imem_req_F);
        end
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 64'h0);
        vec++; if (valid_D !== 1'b1 || pc_D !== 64'h200 || instr_D !== mem_f(64'h200)) begin
            errs++; $display("FAIL b2b_head: got v %b pc %h expected v 1 pc 200", valid_D, pc_D);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] seq [4];
        seq[0] = 64'hFFFF_FFFF_FFFF_FFF8;
        seq[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        seq[2] = 64'h0;
        seq[3] = 64'h4;
        cyc(1'b1, 1'b1, 1'b0, 64'h0);
        for (int c = 0; c < 6; c++) begin
            cyc(1'b0, 1'b1, 1'b0, 64'h0);
            if (c < 4) begin
                vec++; if (addr_w !== seq[c] || req_w !== 1'b1) begin
                    errs++; $display("FAIL wrap_addr c%0d: got %h req %b expected %h req 1", c, addr_w, req_w, seq[c]);
                end
            end
            if (c >= 2) begin
                vec++; if (valid_w !== 1'b1 || pc_w !== seq[c-2] || instr_w !== mem_f(seq[c-2])) begin
                    errs++; $display("FAIL wrap_pc c%0d: got v %b pc %h expected v 1 pc %h", c, valid_w, pc_w, seq[c-2]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, 1'b0, 64'h0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 64'h0);
        vec++; if (fq_count !== 3'd4 || imem_req_F !== 1'b0) begin
            errs++; $display("FAIL rmid_full: got count %0d req %b expected count 4 req 0", fq_count, imem_req_F);
        end
        cyc(1'b1, 1'b1, 1'b0, 64'h0);
        vec++; if (imem_req_F !== 1'b0) begin errs++; $display("FAIL rmid_req: got %b expected 0", imem_req_F); end
        cyc(1'b0, 1'b1, 1'b0, 64'h0);
        vec++; if (valid_D !== 1'b0 || fq_count !== 3'd0 || imem_addr_F !== 64'h0 || imem_req_F !== 1'b1) begin
            errs++; $display("FAIL rmid_after: got v %b count %0d addr %h req %b expected v 0 count 0 addr 0 req 1", valid_D, fq_count, imem_addr_F, imem_req_F);
        end
        cyc(1'b0, 1'b1, 1'b0, 64'h0);
        vec++; if (valid_D !== 1'b0) begin errs++; $display("FAIL rmid_gap: got %b expected 0", valid_D); end
        cyc(1'b0, 1'b1, 1'b0, 64'h0);
        vec++; if (valid_D !== 1'b1 || pc_D !== 64'h0) begin errs++; $display("FAIL rmid_head0: got v %b pc %h expected v 1 pc 0", valid_D, pc_D); end
        cyc(1'b0, 1'b1, 1'b0, 64'h0);
        vec++; if (valid_D !== 1'b1 || pc_D !== 64'h4) begin errs++; $display("FAIL rmid_head1: got v %b pc %h expected v 1 pc 4", valid_D, pc_D); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
